// File: rtl/sha256_msg_sched_if.sv
// Stream bundle between the SHA-256 message scheduler and its producer/consumer.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface sha256_msg_sched_if;
  logic        start_i;
  logic        in_valid_i;
  logic [31:0] in_data_i;
  logic        in_ready_o;
  logic        w_valid_o;
  logic [31:0] w_o;
  logic [5:0]  t_o;
  logic        w_ready_i;
  logic        busy_o;
  logic        done_o;

  modport slave (
    input  start_i,
    input  in_valid_i,
    input  in_data_i,
    output in_ready_o,
    output w_valid_o,
    output w_o,
    output t_o,
    input  w_ready_i,
    output busy_o,
    output done_o
  );

  modport master (
    output start_i,
    output in_valid_i,
    output in_data_i,
    input  in_ready_o,
    input  w_valid_o,
    input  w_o,
    input  t_o,
    output w_ready_i,
    input  busy_o,
    input  done_o
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: passes M[0..15] through, then expands W[16..63]
// in place in a 16-entry circular buffer, one word per cycle into a 1-deep output register.
module sha256_msg_sched (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  sha256_msg_sched_if.slave         bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StExpand, StDrain} state_e;

  state_e      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] w_q, w_d;
  logic [5:0]  t_out_q, t_out_d;
  logic        w_valid_q, w_valid_d;
  logic        done_q, done_d;
  logic [31:0] wbuf_q [16];

  logic        slot_free;
  logic        buf_we;
  logic [31:0] buf_wdata;
  logic [31:0] w_new;
  logic [3:0]  idx_t, idx_m2, idx_m7, idx_m15;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Slot t mod 16 still holds W[t-16] until this cycle's write replaces it.
  assign idx_t   = t_q[3:0];
  assign idx_m2  = idx_t - 4'd2;
  assign idx_m7  = idx_t - 4'd7;
  assign idx_m15 = idx_t - 4'd15;
  assign w_new   = ssig1(wbuf_q[idx_m2]) + wbuf_q[idx_m7] + ssig0(wbuf_q[idx_m15]) + wbuf_q[idx_t];

  assign slot_free      = !w_valid_q || bus.w_ready_i;
  assign bus.in_ready_o = (state_q == StLoad) && slot_free;
  assign bus.w_valid_o  = w_valid_q;
  assign bus.w_o        = w_q;
  assign bus.t_o        = t_out_q;
  assign bus.busy_o     = (state_q != StIdle);
  assign bus.done_o     = done_q;

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    w_d       = w_q;
    t_out_d   = t_out_q;
    w_valid_d = w_valid_q && !bus.w_ready_i;
    done_d    = 1'b0;
    buf_we    = 1'b0;
    buf_wdata = bus.in_data_i;

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d = StLoad;
          t_d     = 6'd0;
        end
      end
      StLoad: begin
        if (bus.in_valid_i && slot_free) begin
          buf_we    = 1'b1;
          w_d       = bus.in_data_i;
          t_out_d   = t_q;
          w_valid_d = 1'b1;
          t_d       = t_q + 6'd1;
          if (t_q == 6'd15) state_d = StExpand;
        end
      end
      StExpand: begin
        if (slot_free) begin
          buf_we    = 1'b1;
          buf_wdata = w_new;
          w_d       = w_new;
          t_out_d   = t_q;
          w_valid_d = 1'b1;
          t_d       = t_q + 6'd1;
          if (t_q == 6'd63) state_d = StDrain;
        end
      end
      StDrain: begin
        if (w_valid_q && bus.w_ready_i) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      t_q       <= '0;
      w_q       <= '0;
      t_out_q   <= '0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 16; i++) wbuf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      w_q       <= w_d;
      t_out_q   <= t_out_d;
      w_valid_q <= w_valid_d;
      done_q    <= done_d;
      if (buf_we) wbuf_q[idx_t] <= buf_wdata;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: known "abc" block, wrap, input gaps,
// ignored start pulses, mid-block reset and randomly back-pressured blocks.
module tb_sha256_msg_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_msg_sched_if bus ();

  sha256_msg_sched dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];
  logic [31:0] rcv   [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void build_model();
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) exp_w[t] = msg[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
      s1 = rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
      exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
    end
  endfunction

  // One block. strict: no stalls, so exact cycle timing is checked.
  task automatic run_block(input bit bp, input int gap_at, input bit glitch,
                           input int abort_t, input bit strict);
    int in_idx = 0;
    int exp_t = 0;
    int cyc = 1;
    int gap_k = 0;
    bit finished = 1'b0;
    bit stalled = 1'b0;
    bit in_gap;
    logic [31:0] held_w = '0;
    logic [5:0]  held_t = '0;

    build_model();
    @(negedge clk);
    bus.start_i = 1'b1;
    #1;
    chk("idle_busy", bus.busy_o, 0);
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    while (!finished && cyc < 2000) begin
      bus.w_ready_i  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_gap         = (in_idx == gap_at) && (gap_k < 3);
      bus.in_valid_i = (in_idx < 16) && !in_gap;
      bus.in_data_i  = bus.in_valid_i ? msg[in_idx] : $urandom;
      bus.start_i    = glitch && (cyc == 5 || cyc == 30);
      #1;
      if (strict && cyc == 1) chk("first_in_ready", bus.in_ready_o, 1);
      if (strict && cyc == 2) chk("first_w_valid", bus.w_valid_o, 1);
      if (in_gap) begin
        chk("gap_in_ready", bus.in_ready_o, 1);
        if (gap_k > 0) chk("gap_w_valid", bus.w_valid_o, 0);
        gap_k++;
      end
      if (stalled) begin
        chk("stall_valid", bus.w_valid_o, 1);
        chk("stall_w", bus.w_o, held_w);
        chk("stall_t", bus.t_o, held_t);
      end
      stalled = bus.w_valid_o && !bus.w_ready_i;
      held_w  = bus.w_o;
      held_t  = bus.t_o;
      if (bus.in_valid_i && bus.in_ready_o) in_idx++;
      if (bus.w_valid_o && bus.w_ready_i) begin
        if (exp_t < 64) begin
          chk("t_order", bus.t_o, exp_t);
          chk("w_value", bus.w_o, exp_w[exp_t]);
          rcv[exp_t] = bus.w_o;
        end
        exp_t++;
      end
      if (bus.done_o) begin
        chk("done_count", exp_t, 64);
        chk("done_w_valid", bus.w_valid_o, 0);
        chk("done_busy", bus.busy_o, 0);
        if (strict) chk("done_cycle", cyc, 66);
        finished = 1'b1;
      end
      if (abort_t >= 0 && exp_t == abort_t) begin
        rst_n = 1'b0;
        #1;
        chk("rst_w_valid", bus.w_valid_o, 0);
        chk("rst_w", bus.w_o, 0);
        chk("rst_t", bus.t_o, 0);
        chk("rst_in_ready", bus.in_ready_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        bus.in_valid_i = 1'b0;
        bus.start_i    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("abort_no_done", bus.done_o, 0);
          chk("abort_idle", bus.busy_o, 0);
          @(negedge clk);
        end
        return;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("block_finished", finished, 1);
    bus.in_valid_i = 1'b0;
    bus.start_i    = 1'b0;
    #1;
    chk("post_done_clear", bus.done_o, 0);
    chk("post_busy", bus.busy_o, 0);
  endtask

  initial begin
    bus.start_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = '0;
    bus.w_ready_i  = 1'b0;
    #12;
    chk("reset_w_valid", bus.w_valid_o, 0);
    chk("reset_w", bus.w_o, 0);
    chk("reset_t", bus.t_o, 0);
    chk("reset_in_ready", bus.in_ready_o, 0);
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_done", bus.done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // "abc" padded block
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0]  = 32'h6162_6380;
    msg[15] = 32'h0000_0018;
    run_block(1'b0, -1, 1'b0, -1, 1'b1);
    chk("abc_w16", rcv[16], 32'h6162_6380);
    chk("abc_w17", rcv[17], 32'h000F_0000);
    chk("abc_w0", rcv[0], 32'h6162_6380);

    // All-ones block exercises the modular wrap
    for (int i = 0; i < 16; i++) msg[i] = 32'hFFFF_FFFF;
    run_block(1'b0, -1, 1'b0, -1, 1'b1);

    // Three-cycle gap on in_valid between M5 and M6
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    run_block(1'b0, 6, 1'b0, -1, 1'b0);

    // start pulses during LOAD and EXPAND are ignored
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    run_block(1'b0, -1, 1'b1, -1, 1'b1);

    // Reset after 30 words, then a fresh block
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    run_block(1'b0, -1, 1'b0, 30, 1'b0);
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    run_block(1'b0, -1, 1'b0, -1, 1'b1);

    // Random blocks under random backpressure
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < 16; i++) msg[i] = $urandom;
      run_block(1'b1, -1, 1'b0, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
# sha256_msg_sched

SHA-256 message-schedule engine for the hash core. It accepts the sixteen 32-bit words of one 512-bit block and emits the 64-word schedule W[0..63] as a valid/ready stream to the compression round logic. Words W[16..63] are computed in place from a 16-entry circular buffer, using the shared rotate-right primitive for the σ0/σ1 functions. Throughput is one word per cycle when both sides keep up.

## Interface
Parameters: none. Word width is fixed at 32 by the SHA-256 definition.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset, asynchronous and active-low
- start_i  in  1  begin a new block; sampled only in IDLE
- in_valid_i  in  1  message word M[t] present on in_data_i
- in_data_i  in  32  message word, big-endian word order M[0] first
- in_ready_o  out  1  engine accepts in_data_i this cycle
- w_valid_o  out  1  w_o/t_o hold a schedule word
- w_o  out  32  schedule word W[t]
- t_o  out  6  index t of w_o (0..63)
- w_ready_i  in  1  consumer accepts w_o this cycle
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse after W[63] is handed off

## Operation
- Core functions, all over 32 bits:
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
  - W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], mod 2^32; carries discarded.
- Buffer: buf[0..15], 32 bits each. Slot t mod 16 holds W[t-16] until W[t] overwrites it.
  - Read slots for W[t]: (t-2), (t-7), (t-15) and t, each mod 16 (4-bit wrap).
- Output register: w_o, t_o and w_valid_o form a single-entry output register.
  - slot_free = !w_valid_o || w_ready_i.
  - A new word is loaded only when slot_free is high.
  - If the register is full and w_ready_i is low, w_o and t_o hold stable.
- Word counter: 6-bit t counts words produced in the current block.
- FSM:
  - IDLE: start_i=1 → LOAD, t←0. Otherwise stay.
  - LOAD: in_ready_o = slot_free.
    - On in_valid_i && in_ready_o: buf[t]←in_data_i, w_o←in_data_i, t_o←t, w_valid_o←1, t←t+1.
    - After t=15 is accepted → EXPAND.
  - EXPAND: in_ready_o=0.
    - When slot_free: compute W[t], write buf[t mod 16], w_o←W[t], t_o←t, w_valid_o←1, t←t+1.
    - After t=63 is produced → DRAIN.
  - DRAIN: wait for the handshake on t_o=63. Then w_valid_o←0, done_o←1 for one cycle → IDLE.
- In any state, w_valid_o clears on a handshake unless a new word is loaded in the same cycle.
- start_i outside IDLE is ignored. in_valid_i outside LOAD is ignored; no word is consumed.
- Reset (asynchronous, any time, including mid-block):
  - state=IDLE, t=0, buf all zero.
  - w_o=0, t_o=0, w_valid_o=0, in_ready_o=0, busy_o=0, done_o=0.
  - The partial block is discarded with no done_o.

## Timing
- Latency: an input accepted at edge k shows on w_o at cycle k+1. A computed W[t] appears the cycle after its slot frees.
- Sustained rate: with in_valid_i and w_ready_i held high, W[0..63] appear on 64 consecutive cycles.
- Example: start_i sampled at edge 0 gives in_ready_o=1 in cycle 1 and W[0] valid in cycle 2. W[63] is valid in cycle 65 with its handshake at edge 65. done_o=1 in cycle 66, busy_o=0 in cycle 66.
- A start_i sampled in the done_o cycle is accepted (state is IDLE).
- Stall rules:
  - A gap on in_valid_i during LOAD leaves a gap on w_valid_o and changes no state.
  - w_ready_i low freezes the engine: t, buf, state and outputs are all unchanged.

## Test plan
- "abc" block: M0=0x61626380, M1..M14=0, M15=0x00000018, streamed back-to-back with w_ready_i=1. Required: W[16]=0x61626380 and W[17]=0x000F0000. All 64 words must match the golden model, and done_o must pulse in cycle 66.
- Random backpressure: w_ready_i toggles pseudo-randomly on 20 random blocks. Required: w_o/t_o stable while stalled, no word dropped or duplicated, t_o runs 0..63 in order.
- Input gaps: in_valid_i low for 3 cycles between M5 and M6. Required: no w_valid_o during the gap, in_ready_o stays high, final schedule unchanged.
- start_i pulsed in LOAD and EXPAND. Required: ignored, same schedule, exactly one done_o.
- rst_ni asserted at t=30, then released and a new block started. Required: all outputs zero immediately during reset, no done_o for the aborted block, new block's schedule correct.
- Wrap/overflow: all inputs 0xFFFFFFFF. Required: every W[t] equals the model with mod-2^32 wrap.
